// File: rtl/approx_mul_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : approx_mul_pkg
//  Description : Shared types and helpers for the iterative approximate
//                multiplier (state encoding, mode values, column mask).
//  Revision    : 1.0 - initial release
// ============================================================================
package approx_mul_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic MODE_EXACT = 1'b0;
    localparam logic MODE_APX   = 1'b1;

    localparam int MASK_MAX = 128;

    // Keep-mask: bit i is set when column i survives truncation.
    function automatic logic [MASK_MAX-1:0] col_keep_mask(input int trunc, input int width);
        logic [MASK_MAX-1:0] m;
        m = '0;
        for (int i = 0; i < MASK_MAX; i++) begin
            if ((i >= trunc) && (i < width)) m[i] = 1'b1;
        end
        return m;
    endfunction

endpackage
`default_nettype wire

// File: rtl/approx_pp_row.sv
`default_nettype none
// ============================================================================
//  Module      : approx_pp_row
//  Description : Combinational generator of one shifted partial-product row,
//                both unmasked and column-truncated.
//  Revision    : 1.0 - initial release
// ============================================================================
module approx_pp_row
    import approx_mul_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int TRUNC = 2,
    parameter int CNT_W = 2
) (
    input  logic [WIDTH-1:0]   i_a,
    input  logic               i_b_bit,
    input  logic [CNT_W-1:0]   i_cnt,
    input  logic               i_mode,
    output logic [2*WIDTH-1:0] o_row_exact,
    output logic [2*WIDTH-1:0] o_row_apx
);

    localparam logic [MASK_MAX-1:0] c_keep_full = col_keep_mask(TRUNC, 2*WIDTH);
    localparam logic [2*WIDTH-1:0]  c_keep      = c_keep_full[2*WIDTH-1:0];

    logic [2*WIDTH-1:0] w_ext;

    assign w_ext       = {{WIDTH{1'b0}}, i_a};
    assign o_row_exact = i_b_bit ? (w_ext << i_cnt) : '0;
    assign o_row_apx   = (i_mode == MODE_APX) ? (o_row_exact & c_keep) : o_row_exact;

endmodule
`default_nettype wire

// File: rtl/approx_mul_iter.sv
`default_nettype none
// ============================================================================
//  Module      : approx_mul_iter
//  Description : Iterative WIDTHxWIDTH unsigned multiplier, one row per cycle,
//                with truncated approximate mode and exact shadow error flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module approx_mul_iter
    import approx_mul_pkg::*;
#(
    parameter int WIDTH      = 4,
    parameter int TRUNC      = 2,
    parameter int ET         = 2,
    parameter int EARLY_TERM = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_a,
    input  logic [WIDTH-1:0]   in_b,
    input  logic               in_mode,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] out_prod,
    output logic               out_err,
    output logic [2*WIDTH-1:0] out_diff
);

    localparam int              CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam int              PW    = 2 * WIDTH;
    localparam logic [PW-1:0]   c_et  = PW'(ET);

    state_t             r_state;
    state_t             w_state_next;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic               r_mode;
    logic [CNT_W-1:0]   r_cnt;
    logic [PW-1:0]      r_acc_exact;
    logic [PW-1:0]      r_acc_apx;
    logic [PW-1:0]      w_row_exact;
    logic [PW-1:0]      w_row_apx;
    logic [PW-1:0]      w_diff;
    logic [WIDTH-1:0]   w_b_upper;
    logic               w_last;

    approx_pp_row #(
        .WIDTH (WIDTH),
        .TRUNC (TRUNC),
        .CNT_W (CNT_W)
    ) u_pp_row (
        .i_a         (r_a),
        .i_b_bit     (r_b[r_cnt]),
        .i_cnt       (r_cnt),
        .i_mode      (r_mode),
        .o_row_exact (w_row_exact),
        .o_row_apx   (w_row_apx)
    );

    // Extra counter bit keeps cnt+1 from wrapping when WIDTH is a power of two.
    assign w_b_upper = r_b >> ({1'b0, r_cnt} + 1'b1);
    assign w_last    = (r_cnt == CNT_W'(WIDTH-1)) ||
                       ((EARLY_TERM != 0) && (w_b_upper == '0));
    assign w_diff    = r_acc_exact - r_acc_apx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        out_prod     = '0;
        out_diff     = '0;
        out_err      = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) w_state_next = BUSY;
            end
            BUSY: begin
                if (w_last) w_state_next = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                out_prod  = r_acc_apx;
                out_diff  = w_diff;
                out_err   = (w_diff > c_et);
                if (out_ready) w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a         <= '0;
            r_b         <= '0;
            r_mode      <= MODE_EXACT;
            r_cnt       <= '0;
            r_acc_exact <= '0;
            r_acc_apx   <= '0;
        end else if ((r_state == IDLE) && in_valid) begin
            r_a         <= in_a;
            r_b         <= in_b;
            r_mode      <= in_mode;
            r_cnt       <= '0;
            r_acc_exact <= '0;
            r_acc_apx   <= '0;
        end else if (r_state == BUSY) begin
            r_acc_exact <= r_acc_exact + w_row_exact;
            r_acc_apx   <= r_acc_apx + w_row_apx;
            r_cnt       <= r_cnt + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_approx_mul_iter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_approx_mul_iter
//  Description : Directed and scoreboard bench for approx_mul_iter with
//                EARLY_TERM=0 (dut0) and EARLY_TERM=1 (dut1) instances.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_approx_mul_iter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] in_a = '0;
    logic [3:0] in_b = '0;
    logic       in_mode = 1'b0;
    logic [1:0] in_valid = 2'b00;
    logic [1:0] out_ready = 2'b11;
    logic [1:0] in_ready;
    logic [1:0] out_valid;
    logic [1:0] out_err;
    logic [7:0] out_prod [2];
    logic [7:0] out_diff [2];

    int n_total = 0;
    int n_pass  = 0;

    typedef struct {
        int d;
        int a;
        int b;
        int m;
        int prod;
        int diff;
        int err;
        int lat;
    } vec_t;

    vec_t vecs [10];

    always #5 clk = ~clk;

    approx_mul_iter #(.WIDTH(4), .TRUNC(2), .ET(2), .EARLY_TERM(0)) dut0 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid[0]),
        .in_ready  (in_ready[0]),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_mode   (in_mode),
        .out_valid (out_valid[0]),
        .out_ready (out_ready[0]),
        .out_prod  (out_prod[0]),
        .out_err   (out_err[0]),
        .out_diff  (out_diff[0])
    );

    approx_mul_iter #(.WIDTH(4), .TRUNC(2), .ET(2), .EARLY_TERM(1)) dut1 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid[1]),
        .in_ready  (in_ready[1]),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_mode   (in_mode),
        .out_valid (out_valid[1]),
        .out_ready (out_ready[1]),
        .out_prod  (out_prod[1]),
        .out_err   (out_err[1]),
        .out_diff  (out_diff[1])
    );

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Operands are scrambled right after acceptance to prove they are latched.
    task automatic start_op(input int d, input int a, input int b, input int m);
        in_a        = 4'(a);
        in_b        = 4'(b);
        in_mode     = 1'(m);
        in_valid[d] = 1'b1;
        tick();
        in_valid[d] = 1'b0;
        in_a        = ~in_a;
        in_b        = ~in_b;
        in_mode     = ~in_mode;
    endtask

    task automatic wait_valid(input int d, output int lat);
        lat = 0;
        while (!out_valid[d] && lat < 16) begin
            tick();
            lat++;
        end
        if (!out_valid[d]) check($sformatf("timeout_dut%0d", d), 0, 1);
    endtask

    task automatic run_op(input int d, input int a, input int b, input int m,
                          output int prod, output int diff, output int err, output int lat);
        start_op(d, a, b, m);
        wait_valid(d, lat);
        prod = int'(out_prod[d]);
        diff = int'(out_diff[d]);
        err  = int'(out_err[d]);
        tick();
    endtask

    function automatic void model(input int a, input int b, input int m, input int et,
                                  output int prod, output int diff, output int err, output int lat);
        int exact;
        int apx;
        int hb;
        exact = a * b;
        apx   = 0;
        hb    = 0;
        for (int i = 0; i < 4; i++) begin
            if (((b >> i) & 1) == 1) begin
                apx += (m != 0) ? ((a << i) & 'hFC) : (a << i);
                hb   = i + 1;
            end
        end
        prod = apx;
        diff = exact - apx;
        err  = (diff > 2) ? 1 : 0;
        lat  = (et == 0) ? 4 : ((hb == 0) ? 1 : hb);
    endfunction

    initial begin
        int p, df, e, l;
        int ep, ed, ee, el;

        //           d   a   b  m  prod diff err lat
        vecs[0] = '{0,  3,  3, 1,   4,  5,  1,  4};
        vecs[1] = '{0, 15, 15, 1, 220,  5,  1,  4};
        vecs[2] = '{0, 15, 15, 0, 225,  0,  0,  4};
        vecs[3] = '{1,  4,  5, 1,  20,  0,  0,  3};
        vecs[4] = '{1,  4,  1, 1,   4,  0,  0,  1};
        vecs[5] = '{1,  7,  0, 1,   0,  0,  0,  1};
        vecs[6] = '{1, 15, 15, 0, 225,  0,  0,  4};
        vecs[7] = '{0,  5,  2, 1,   8,  2,  0,  4};
        vecs[8] = '{1,  7,  2, 1,  12,  2,  0,  2};
        vecs[9] = '{1,  1,  3, 1,   0,  3,  1,  2};

        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            check($sformatf("reset_out_valid_dut%0d", d), int'(out_valid[d]), 0);
            check($sformatf("reset_in_ready_dut%0d", d), int'(in_ready[d]), 1);
            check($sformatf("reset_out_prod_dut%0d", d), int'(out_prod[d]), 0);
            check($sformatf("reset_out_diff_dut%0d", d), int'(out_diff[d]), 0);
            check($sformatf("reset_out_err_dut%0d", d), int'(out_err[d]), 0);
        end
        tick();

        for (int i = 0; i < 10; i++) begin
            run_op(vecs[i].d, vecs[i].a, vecs[i].b, vecs[i].m, p, df, e, l);
            check($sformatf("vec%0d_prod", i), p, vecs[i].prod);
            check($sformatf("vec%0d_diff", i), df, vecs[i].diff);
            check($sformatf("vec%0d_err", i), e, vecs[i].err);
            check($sformatf("vec%0d_latency", i), l, vecs[i].lat);
        end

        // Backpressure: result must hold while in_valid pulses are ignored.
        out_ready[0] = 1'b0;
        start_op(0, 3, 3, 1);
        wait_valid(0, l);
        check("bp_latency", l, 4);
        for (int c = 0; c < 5; c++) begin
            in_a        = 4'd5;
            in_b        = 4'd5;
            in_valid[0] = 1'b1;
            tick();
            in_valid[0] = 1'b0;
            check($sformatf("bp%0d_out_valid", c), int'(out_valid[0]), 1);
            check($sformatf("bp%0d_prod", c), int'(out_prod[0]), 4);
            check($sformatf("bp%0d_diff", c), int'(out_diff[0]), 5);
            check($sformatf("bp%0d_err", c), int'(out_err[0]), 1);
            check($sformatf("bp%0d_in_ready", c), int'(in_ready[0]), 0);
        end
        out_ready[0] = 1'b1;
        tick();
        check("bp_release_out_valid", int'(out_valid[0]), 0);
        check("bp_release_in_ready", int'(in_ready[0]), 1);

        // Reset while a result is held in DONE must drop it at once.
        out_ready[1] = 1'b0;
        start_op(1, 15, 15, 1);
        wait_valid(1, l);
        check("rst_done_pre_valid", int'(out_valid[1]), 1);
        #2 rst = 1'b1;
        #1;
        check("rst_done_out_valid", int'(out_valid[1]), 0);
        check("rst_done_out_prod", int'(out_prod[1]), 0);
        check("rst_done_out_diff", int'(out_diff[1]), 0);
        check("rst_done_out_err", int'(out_err[1]), 0);
        @(posedge clk);
        #3 rst = 1'b0;
        out_ready[1] = 1'b1;
        #1;
        check("rst_done_in_ready", int'(in_ready[1]), 1);
        tick();

        // Reset in the second BUSY cycle, then a fresh exact operation.
        start_op(0, 15, 15, 1);
        tick();
        #2 rst = 1'b1;
        #1;
        check("rst_busy_in_ready", int'(in_ready[0]), 1);
        check("rst_busy_out_valid", int'(out_valid[0]), 0);
        check("rst_busy_out_prod", int'(out_prod[0]), 0);
        @(posedge clk);
        #3 rst = 1'b0;
        #1;
        check("rst_busy_release_in_ready", int'(in_ready[0]), 1);
        tick();
        run_op(0, 2, 3, 0, p, df, e, l);
        check("post_rst_prod", p, 6);
        check("post_rst_diff", df, 0);
        check("post_rst_err", e, 0);
        check("post_rst_latency", l, 4);

        // Back-to-back random operations against the reference model.
        for (int i = 0; i < 20; i++) begin
            int d, a, b, m;
            d = i % 2;
            a = $urandom_range(0, 15);
            b = $urandom_range(0, 15);
            m = $urandom_range(0, 1);
            model(a, b, m, d, ep, ed, ee, el);
            run_op(d, a, b, m, p, df, e, l);
            check($sformatf("rnd%0d_prod a=%0d b=%0d m=%0d", i, a, b, m), p, ep);
            check($sformatf("rnd%0d_diff", i), df, ed);
            check($sformatf("rnd%0d_err", i), e, ee);
            check($sformatf("rnd%0d_latency", i), l, el);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/approx_mul_iter.md
Name: approx_mul_iter

Overview:
Parametrised, iterative successor to the generated combinational approximate multipliers. It computes an unsigned WIDTH x WIDTH product one partial-product row per cycle. In approximate mode it drops partial-product columns below TRUNC. An exact shadow accumulator runs in parallel, and the block flags when the approximation error exceeds a threshold ET. It sits behind valid/ready handshakes so it can drop into datapaths that evaluate approximate arithmetic at run time.

Parameters:
WIDTH, 4, operand width in bits (>=2).
TRUNC, 2, partial-product columns [TRUNC-1:0] forced to 0 in approximate mode (0..2*WIDTH).
ET, 2, error threshold; out_err=1 when exact-approx > ET.
EARLY_TERM, 1, 1 = stop iterating once no set multiplier bits remain.

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
in_valid  in  1  operand request
in_ready  out  1  block can accept operands
in_a  in  WIDTH  multiplicand
in_b  in  WIDTH  multiplier
in_mode  in  1  0 = exact, 1 = approximate
out_valid  out  1  result available
out_ready  in  1  consumer accepts result
out_prod  out  2*WIDTH  product (approximate if mode=1)
out_err  out  1  (exact-approx) > ET
out_diff  out  2*WIDTH  exact-approx

Behaviour:
- Interface: one clock; reset is asynchronous and active-high.
- Reset (asserted at any time, including mid-operation): state=IDLE, accumulators=0, counter=0, out_valid=0, out_prod=0, out_err=0, out_diff=0, in_ready=1 once released. Any in-flight operation is discarded.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - in_ready=1.
  - Accept on in_valid & in_ready: latch a, b and mode; clear both accumulators; cnt=0; go to BUSY.
- BUSY:
  - in_ready=0.
  - Each cycle: row = (b[cnt] ? a : 0) << cnt, 2*WIDTH bits.
  - acc_exact += row.
  - acc_apx += row & ~((1<<TRUNC)-1) when mode=1; acc_apx += row when mode=0.
  - cnt++.
  - Go to DONE after processing cnt==WIDTH-1, or when EARLY_TERM=1 and b[WIDTH-1:cnt+1]==0.
  - The last row is included in the registered result.
- DONE:
  - out_valid=1; out_prod=acc_apx; out_diff=acc_exact-acc_apx; out_err=(out_diff>ET).
  - Outputs are held stable until out_ready. On out_valid & out_ready go to IDLE.
  - in_ready=0 in DONE, so there is no same-cycle accept.
- Latency: out_valid rises k edges after the accepting edge.
  - k = WIDTH when EARLY_TERM=0.
  - k = max(1, index of highest set bit of b + 1) when EARLY_TERM=1.
  - b=0 with EARLY_TERM=1 gives k=1.
- Throughput: at most one operation per k+2 cycles, given out_ready held high.
- Arithmetic:
  - Unsigned. Accumulators are 2*WIDTH bits and cannot overflow.
  - Masking only removes bits, so acc_apx <= acc_exact and out_diff is never negative.
  - mode=0 gives out_diff=0 and out_err=0.
- in_a, in_b and in_mode are ignored outside the accepting cycle; changes during BUSY have no effect.
- out_ready while out_valid=0 is ignored.
- TRUNC=0: approximate equals exact. TRUNC>=2*WIDTH: approximate product is 0.

Decomposition:
- Shared package approx_mul_pkg holds:
  - state enum {IDLE, BUSY, DONE};
  - mode constants MODE_EXACT=0, MODE_APX=1;
  - a function computing the column mask from TRUNC and width.
- Natural sub-module: approx_pp_row. It is combinational and generates the masked and unmasked shifted row from a, b[cnt], cnt and mode.
- The top holds the FSM, counter, accumulators and handshake.

Test Plan:
(All with WIDTH=4, TRUNC=2, ET=2 unless stated.)
- EARLY_TERM=0, mode=1, a=3, b=3 -> out_valid 4 edges after accept; out_prod=4, out_diff=5, out_err=1.
- mode=1, a=15, b=15 -> out_prod=220, out_diff=5, out_err=1; mode=0, same operands -> out_prod=225, out_diff=0, out_err=0.
- EARLY_TERM=1, mode=1, a=4, b=5 -> out_valid 3 edges after accept; out_prod=20, out_diff=0, out_err=0. b=1 -> 1 edge; b=0 -> out_prod=0 after 1 edge.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid -> out_prod, out_err and out_diff stable; in_ready=0 throughout; in_valid pulses ignored; release -> IDLE next edge and in_ready=1.
- Assert rst in the 2nd BUSY cycle -> out_valid=0 and outputs 0 immediately (asynchronous). After release, a new op a=2, b=3, mode=0 gives out_prod=6.
- Back-to-back: 20 random operand pairs with out_ready=1 and a scoreboard model checking the exact/approx products, diff, err and the latency formula.
